// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial packet receiver: FSM state encoding,
// default geometry and the byte-counter width helper.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } serial_state_e;

   localparam int          SERIAL_PKT_BYTES_DEF = 84;
   localparam logic [23:0] SERIAL_TIMEOUT_DEF   = 24'h800000;

   // Counter must hold 0..PKT_BYTES+1 (payload plus optional checksum byte).
   function automatic int serial_cnt_width(input int pkt_bytes);
      return $clog2(pkt_bytes + 2);
   endfunction

endpackage

// File: rtl/serial_idle_timer.sv
// Inter-byte idle timer: counts while enabled, raises expired on the last count
// and wraps to zero on its own; clear has priority over counting.
module serial_idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [23:0] LAST = 24'(TIMEOUT_CYCLES - 1);

   logic [23:0] cnt_q, cnt_d;

   assign expired = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || expired) cnt_d = '0;
      else if (enable)      cnt_d = cnt_q + 24'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serial_packet_rx.sv
// Assembles rx_valid byte strobes into a PKT_BYTES payload with idle timeout and
// overrun flagging. Define SERIAL_RX_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for byte 0 of a frame
// RECV   | frame partially received, idle timer running
// COMMIT | full frame held in buffer, published to out_data this cycle
module serial_packet_rx
   import serial_pkg::*;
#(
   parameter int PKT_BYTES      = SERIAL_PKT_BYTES_DEF,
   parameter int TIMEOUT_CYCLES = int'(SERIAL_TIMEOUT_DEF)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_byte,
   output logic [PKT_BYTES*8-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   err_timeout,
   output logic                   err_overrun,
   output logic                   err_cksum
);

   localparam int W  = PKT_BYTES * 8;
   localparam int CW = serial_cnt_width(PKT_BYTES);
`ifdef SERIAL_RX_CHECKSUM_EN
   localparam int FRAME_LEN = PKT_BYTES + 1;
`else
   localparam int FRAME_LEN = PKT_BYTES;
`endif
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] PAYLOAD    = CW'(PKT_BYTES);

   serial_state_e   state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, idx;
   logic [W-1:0]    buf_q, buf_d, out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d, busy_q, busy_d;
   logic            err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
   logic            expired, commit_ok;
`ifdef SERIAL_RX_CHECKSUM_EN
   logic [7:0]      cksum_q, cksum_d;
   logic            cksum_bad_q, cksum_bad_d, err_cksum_q, err_cksum_d;
`endif

   serial_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .enable  (state_q == RECV),
      .expired (expired)
   );

   // A byte arriving outside RECV (IDLE or COMMIT) always starts a new frame.
   assign idx = (state_q == RECV) ? cnt_q : '0;

`ifdef SERIAL_RX_CHECKSUM_EN
   assign commit_ok = !cksum_bad_q;
`else
   assign commit_ok = 1'b1;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      buf_d         = buf_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
`ifdef SERIAL_RX_CHECKSUM_EN
      cksum_d       = cksum_q;
      cksum_bad_d   = cksum_bad_q;
      err_cksum_d   = 1'b0;
`endif

      if (rx_valid) begin
         cnt_d   = idx + CW'(1);
         state_d = (idx == FRAME_LAST) ? COMMIT : RECV;
         if (idx < PAYLOAD) buf_d = (buf_q << 8) | W'(rx_byte);
`ifdef SERIAL_RX_CHECKSUM_EN
         if (idx == '0)          cksum_d = rx_byte;
         else if (idx < PAYLOAD) cksum_d = cksum_q ^ rx_byte;
         if (idx == PAYLOAD) begin
            cksum_bad_d = (rx_byte != cksum_q);
            err_cksum_d = (rx_byte != cksum_q);
         end
`endif
      end else if (state_q == RECV && expired) begin
         state_d       = IDLE;
         cnt_d         = '0;
         err_timeout_d = 1'b1;
      end else if (state_q == COMMIT) begin
         state_d = IDLE;
         cnt_d   = '0;
      end

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      // A commit overrides a coincident handshake, so the new packet stays valid.
      if (state_q == COMMIT && commit_ok) begin
         out_data_d    = buf_q;
         out_valid_d   = 1'b1;
         err_overrun_d = out_valid_q && !out_ready;
      end

      busy_d = (state_d == RECV);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         buf_q         <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
`ifdef SERIAL_RX_CHECKSUM_EN
         cksum_q       <= '0;
         cksum_bad_q   <= 1'b0;
         err_cksum_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         buf_q         <= buf_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
`ifdef SERIAL_RX_CHECKSUM_EN
         cksum_q       <= cksum_d;
         cksum_bad_q   <= cksum_bad_d;
         err_cksum_q   <= err_cksum_d;
`endif
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
`ifdef SERIAL_RX_CHECKSUM_EN
   assign err_cksum   = err_cksum_q;
`else
   assign err_cksum   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_packet_rx.sv
// Directed bench for serial_packet_rx with PKT_BYTES=4, TIMEOUT_CYCLES=16.
// Adds the checksum scenario when SERIAL_RX_CHECKSUM_EN is defined.
module tb_serial_packet_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_valid, busy, err_timeout, err_overrun, err_cksum;

   int n_cmp = 0;
   int n_bad = 0;

   serial_packet_rx #(.PKT_BYTES(4), .TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .err_cksum   (err_cksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic        rdy;
      logic        ov;
      logic [31:0] data;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] b);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] ck(input logic [31:0] p);
      return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
   endfunction

   // Sends one full frame; the checksum byte is appended in the checksum build.
   task automatic send_pkt(input logic [31:0] p);
      step(1'b1, p[31:24]);
      step(1'b1, p[23:16]);
      step(1'b1, p[15:8]);
      step(1'b1, p[7:0]);
`ifdef SERIAL_RX_CHECKSUM_EN
      step(1'b1, ck(p));
`endif
   endtask

   task automatic send_ck(input logic [31:0] p);
`ifdef SERIAL_RX_CHECKSUM_EN
      step(1'b1, ck(p));
`else
      if (p == 32'hFFFF_FFFF) $display("note: unreachable");
`endif
   endtask

   task automatic add_vec(input logic v, input logic [7:0] b, input logic rdy,
                          input logic ov, input logic [31:0] data, input logic bz);
      vec_t r;
      r.v = v; r.b = b; r.rdy = rdy; r.ov = ov; r.data = data; r.busy = bz;
      vecs.push_back(r);
   endtask

   initial begin
      add_vec(1'b1, 8'h11, 1'b1, 1'b0, 32'h0, 1'b1);
      add_vec(1'b1, 8'h22, 1'b1, 1'b0, 32'h0, 1'b1);
      add_vec(1'b1, 8'h33, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef SERIAL_RX_CHECKSUM_EN
      add_vec(1'b1, 8'h44, 1'b1, 1'b0, 32'h0, 1'b1);
      add_vec(1'b1, 8'h44, 1'b1, 1'b0, 32'h0, 1'b0);
`else
      add_vec(1'b1, 8'h44, 1'b1, 1'b0, 32'h0, 1'b0);
`endif
      add_vec(1'b0, 8'h00, 1'b1, 1'b1, 32'h11223344, 1'b0);
      add_vec(1'b0, 8'h00, 1'b1, 1'b0, 32'h11223344, 1'b0);
      add_vec(1'b0, 8'h00, 1'b0, 1'b0, 32'h11223344, 1'b0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_errs", {29'h0, err_timeout, err_overrun, err_cksum}, 32'h0);
      rst_n = 1'b1;

      // Basic packet, table driven
      foreach (vecs[i]) begin
         out_ready = vecs[i].rdy;
         step(vecs[i].v, vecs[i].b);
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         check($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_errs", i), {29'h0, err_timeout, err_overrun, err_cksum}, 32'h0);
      end

      // Timeout 16 cycles after the 2nd byte, then a clean packet
      out_ready = 1'b1;
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      for (int j = 1; j <= 20; j++) begin
         step(1'b0, 8'h00);
         check($sformatf("to_pulse_c%0d", j), 32'(err_timeout), 32'(j == 16));
         if (j == 15 || j == 16)
            check($sformatf("to_busy_c%0d", j), 32'(busy), 32'(j < 16));
      end
      send_pkt(32'hA1B2C3D4);
      step(1'b0, 8'h00);
      check("to_next_data", out_data, 32'hA1B2C3D4);
      check("to_next_valid", 32'(out_valid), 32'h1);
      step(1'b0, 8'h00);

      // Overrun
      out_ready = 1'b0;
      send_pkt(32'hAABBCCDD);
      step(1'b0, 8'h00);
      check("ovr_first_data", out_data, 32'hAABBCCDD);
      check("ovr_first_flag", 32'(err_overrun), 32'h0);
      send_pkt(32'h01020304);
      step(1'b0, 8'h00);
      check("ovr_flag", 32'(err_overrun), 32'h1);
      check("ovr_data", out_data, 32'h01020304);
      check("ovr_valid", 32'(out_valid), 32'h1);
      step(1'b0, 8'h00);
      check("ovr_pulse_end", 32'(err_overrun), 32'h0);
      check("ovr_valid_held", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      step(1'b0, 8'h00);
      check("ovr_consumed", 32'(out_valid), 32'h0);

`ifdef SERIAL_RX_CHECKSUM_EN
      out_ready = 1'b0;
      send_pkt(32'h01020408);
      step(1'b0, 8'h00);
      check("ck_good_data", out_data, 32'h01020408);
      check("ck_good_valid", 32'(out_valid), 32'h1);
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      step(1'b1, 8'h04);
      step(1'b1, 8'h08);
      step(1'b1, 8'h00);
      check("ck_bad_pulse", 32'(err_cksum), 32'h1);
      step(1'b0, 8'h00);
      check("ck_bad_pulse_end", 32'(err_cksum), 32'h0);
      check("ck_bad_data", out_data, 32'h01020408);
      check("ck_bad_valid", 32'(out_valid), 32'h1);
      check("ck_bad_no_ovr", 32'(err_overrun), 32'h0);
      out_ready = 1'b1;
      step(1'b0, 8'h00);
`endif

      // Reset asserted mid-packet
      out_ready = 1'b0;
      send_pkt(32'h12345678);
      step(1'b0, 8'h00);
      check("mr_pending", 32'(out_valid), 32'h1);
      step(1'b1, 8'h99);
      step(1'b1, 8'h98);
      step(1'b1, 8'h97);
      check("mr_busy_before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #2;
      check("mr_out_data", out_data, 32'h0);
      check("mr_out_valid", 32'(out_valid), 32'h0);
      check("mr_busy", 32'(busy), 32'h0);
      check("mr_errs", {29'h0, err_timeout, err_overrun, err_cksum}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_pkt(32'h5A6B7C8D);
      step(1'b0, 8'h00);
      check("mr_new_data", out_data, 32'h5A6B7C8D);
      check("mr_new_valid", 32'(out_valid), 32'h1);
      step(1'b0, 8'h00);

      // Byte on the exact expiry cycle, then a byte on the COMMIT cycle
      step(1'b1, 8'h10);
      repeat (15) step(1'b0, 8'h00);
      step(1'b1, 8'h20);
      check("edge_no_timeout", 32'(err_timeout), 32'h0);
      check("edge_busy", 32'(busy), 32'h1);
      step(1'b1, 8'h30);
      step(1'b1, 8'h40);
      send_ck(32'h10203040);
      step(1'b1, 8'h0B);
      check("cm_data", out_data, 32'h10203040);
      check("cm_valid", 32'(out_valid), 32'h1);
      check("cm_busy", 32'(busy), 32'h1);
      check("cm_no_timeout", 32'(err_timeout), 32'h0);
      step(1'b1, 8'h0C);
      step(1'b1, 8'h0D);
      step(1'b1, 8'h0E);
      send_ck(32'h0B0C0D0E);
      step(1'b0, 8'h00);
      check("cm_next_data", out_data, 32'h0B0C0D0E);
      check("cm_next_valid", 32'(out_valid), 32'h1);
      check("cm_err_cksum", 32'(err_cksum), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
